// File: rtl/vga_fb_arbiter_if.sv
// Bundle of every non-clock/reset signal around the framebuffer arbiter.
//   slave  : seen from the arbiter (takes hpos/vpos, host command, RAM read data;
//            drives host grant/read-back, RAM command and the display word)
//   master : seen from the environment (sync generator, host, RAM, pixel shifter)
interface vga_fb_arbiter_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8
);
    logic [9:0]        hpos;
    logic [9:0]        vpos;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] vid_word;
    logic              vid_strobe;

    modport slave (
        input  hpos, vpos, host_req, host_we, host_addr, host_wdata, mem_rdata,
        output host_gnt, host_rvalid, host_rdata, mem_en, mem_we, mem_addr, mem_wdata,
               vid_word, vid_strobe
    );

    modport master (
        output hpos, vpos, host_req, host_we, host_addr, host_wdata, mem_rdata,
        input  host_gnt, host_rvalid, host_rdata, mem_en, mem_we, mem_addr, mem_wdata,
               vid_word, vid_strobe
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: shares one single-port synchronous RAM between the
// display fetch path and a host read/write port. Video fetches are scheduled
// FETCH_LEAD pixels ahead of each word boundary and always win; the host gets
// every other free cycle.
// Ports:
//   clk   : pixel clock
//   rst_n : asynchronous active-low reset
//   bus   : vga_fb_arbiter_if.slave (sync position, host port, RAM port, video word)
module vga_fb_arbiter #(
    parameter int unsigned H_DISPLAY      = 640,
    parameter int unsigned H_TOTAL        = 800,
    parameter int unsigned V_DISPLAY      = 480,
    parameter int unsigned V_TOTAL        = 525,
    parameter int unsigned PIX_PER_WORD   = 8,
    parameter int unsigned WORDS_PER_LINE = 80,
    parameter int unsigned ROW_SHIFT      = 4,
    parameter int unsigned FETCH_LEAD     = 3,
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned DATA_W         = 8
) (
    input logic            clk,
    input logic            rst_n,
    vga_fb_arbiter_if.slave bus
);
    localparam int unsigned PPW_LOG     = $clog2(PIX_PER_WORD);
    localparam logic [10:0] L_H_TOTAL   = 11'(H_TOTAL);
    localparam logic [10:0] L_H_DISPLAY = 11'(H_DISPLAY);
    localparam logic [10:0] L_V_TOTAL   = 11'(V_TOTAL);
    localparam logic [10:0] L_V_DISPLAY = 11'(V_DISPLAY);
    localparam logic [10:0] L_PPW_MASK  = 11'(PIX_PER_WORD - 1);

    logic [10:0]       w_th_raw;
    logic [10:0]       w_vp1;
    logic [10:0]       w_th;
    logic [10:0]       w_tv;
    logic              w_vid_slot;
    logic              w_host_go;
    logic [ADDR_W-1:0] w_vid_addr;

    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_host_gnt;
    logic              r_host_rvalid;
    logic [DATA_W-1:0] r_host_rdata;
    logic [DATA_W-1:0] r_vid_word;
    logic              r_vid_strobe;
    // Read tags: stage 1 travels with the command, stage 2 with the RAM data.
    logic              r_t1_vld;
    logic              r_t1_vid;
    logic              r_t2_vld;
    logic              r_t2_vid;

    // Target pixel this cycle's decision serves, wrapping into the next line/frame.
    assign w_th_raw = {1'b0, bus.hpos} + 11'(FETCH_LEAD);
    assign w_vp1    = {1'b0, bus.vpos} + 11'd1;

    always_comb begin
        w_th = w_th_raw;
        w_tv = {1'b0, bus.vpos};
        if (w_th_raw >= L_H_TOTAL) begin
            w_th = w_th_raw - L_H_TOTAL;
            w_tv = (w_vp1 == L_V_TOTAL) ? 11'd0 : w_vp1;
        end
    end

    assign w_vid_slot = ((w_th & L_PPW_MASK) == 11'd0) && (w_th < L_H_DISPLAY) &&
                        (w_tv < L_V_DISPLAY);
    assign w_vid_addr = ADDR_W'(32'(w_tv >> ROW_SHIFT) * WORDS_PER_LINE +
                                32'(w_th >> PPW_LOG));
    // A grant already showing this cycle blocks a second one back-to-back.
    assign w_host_go  = bus.host_req && !r_host_gnt && !w_vid_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_en      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_host_gnt    <= 1'b0;
            r_host_rvalid <= 1'b0;
            r_host_rdata  <= '0;
            r_vid_word    <= '0;
            r_vid_strobe  <= 1'b0;
            r_t1_vld      <= 1'b0;
            r_t1_vid      <= 1'b0;
            r_t2_vld      <= 1'b0;
            r_t2_vid      <= 1'b0;
        end else begin
            if (w_vid_slot) begin
                r_mem_en   <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= w_vid_addr;
                r_host_gnt <= 1'b0;
                r_t1_vld   <= 1'b1;
                r_t1_vid   <= 1'b1;
            end else if (w_host_go) begin
                r_mem_en    <= 1'b1;
                r_mem_we    <= bus.host_we;
                r_mem_addr  <= bus.host_addr;
                r_mem_wdata <= bus.host_wdata;
                r_host_gnt  <= 1'b1;
                r_t1_vld    <= !bus.host_we;
                r_t1_vid    <= 1'b0;
            end else begin
                r_mem_en   <= 1'b0;
                r_mem_we   <= 1'b0;
                r_host_gnt <= 1'b0;
                r_t1_vld   <= 1'b0;
                r_t1_vid   <= 1'b0;
            end

            r_t2_vld <= r_t1_vld;
            r_t2_vid <= r_t1_vid;

            r_vid_strobe  <= r_t2_vld && r_t2_vid;
            r_host_rvalid <= r_t2_vld && !r_t2_vid;
            if (r_t2_vld && r_t2_vid) begin
                r_vid_word <= bus.mem_rdata;
            end
            if (r_t2_vld && !r_t2_vid) begin
                r_host_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_en      = r_mem_en;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.host_gnt    = r_host_gnt;
    assign bus.host_rvalid = r_host_rvalid;
    assign bus.host_rdata  = r_host_rdata;
    assign bus.vid_word    = r_vid_word;
    assign bus.vid_strobe  = r_vid_strobe;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int unsigned cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int gnt_cnt = 0;

    typedef struct {
        int unsigned cyc;
        logic        gnt;
        logic        we;
        logic [11:0] addr;
        logic [7:0]  wdata;
    } cmd_t;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  data;
    } rd_t;

    cmd_t cmd_q[$];
    rd_t  vid_q[$];
    rd_t  hrd_q[$];

    logic [7:0] ram [4096];

    vga_fb_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus ();

    vga_fb_arbiter #(
        .H_DISPLAY(640), .H_TOTAL(800), .V_DISPLAY(480), .V_TOTAL(525),
        .PIX_PER_WORD(8), .WORDS_PER_LINE(80), .ROW_SHIFT(4), .FETCH_LEAD(3),
        .ADDR_W(12), .DATA_W(8)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port synchronous RAM behind the arbiter.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    function automatic void exp_cmd(input int unsigned at, input logic gnt, input logic we,
                                    input logic [11:0] a, input logic [7:0] d);
        cmd_t e;
        e.cyc = at; e.gnt = gnt; e.we = we; e.addr = a; e.wdata = d;
        cmd_q.push_back(e);
    endfunction

    function automatic void exp_vid(input int unsigned at, input logic [7:0] d);
        rd_t e;
        e.cyc = at; e.data = d;
        vid_q.push_back(e);
    endfunction

    function automatic void exp_hrd(input int unsigned at, input logic [7:0] d);
        rd_t e;
        e.cyc = at; e.data = d;
        hrd_q.push_back(e);
    endfunction

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
        end
    endtask

    // Monitor: every DUT output event is popped against the scoreboard.
    always @(negedge clk) begin
        cmd_t c;
        rd_t  r;
        if (rst_n) begin
            if (bus.mem_en || bus.host_gnt) begin
                n_cmp++;
                if (bus.host_gnt) gnt_cnt++;
                if (cmd_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL cmd_unexpected: got en=%0b gnt=%0b we=%0b addr=0x%h at cyc %0d, required none",
                             bus.mem_en, bus.host_gnt, bus.mem_we, bus.mem_addr, cyc);
                end else begin
                    c = cmd_q.pop_front();
                    if (cyc != c.cyc || !bus.mem_en || bus.host_gnt != c.gnt ||
                        bus.mem_we != c.we || bus.mem_addr != c.addr ||
                        (c.we && bus.mem_wdata != c.wdata)) begin
                        n_bad++;
                        $display("FAIL cmd: got cyc=%0d en=%0b gnt=%0b we=%0b addr=0x%h wd=0x%h, required cyc=%0d en=1 gnt=%0b we=%0b addr=0x%h wd=0x%h",
                                 cyc, bus.mem_en, bus.host_gnt, bus.mem_we, bus.mem_addr,
                                 bus.mem_wdata, c.cyc, c.gnt, c.we, c.addr, c.wdata);
                    end
                end
            end
            if (bus.vid_strobe) begin
                n_cmp++;
                if (vid_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL vid_unexpected: got strobe word=0x%h at cyc %0d, required none",
                             bus.vid_word, cyc);
                end else begin
                    r = vid_q.pop_front();
                    if (cyc != r.cyc || bus.vid_word != r.data) begin
                        n_bad++;
                        $display("FAIL vid: got cyc=%0d word=0x%h, required cyc=%0d word=0x%h",
                                 cyc, bus.vid_word, r.cyc, r.data);
                    end
                end
            end
            if (bus.host_rvalid) begin
                n_cmp++;
                if (hrd_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rvalid_unexpected: got rdata=0x%h at cyc %0d, required none",
                             bus.host_rdata, cyc);
                end else begin
                    r = hrd_q.pop_front();
                    if (cyc != r.cyc || bus.host_rdata != r.data) begin
                        n_bad++;
                        $display("FAIL host_rd: got cyc=%0d data=0x%h, required cyc=%0d data=0x%h",
                                 cyc, bus.host_rdata, r.cyc, r.data);
                    end
                end
            end
        end
    end

    // One cycle of sync-generator position, driven just after the edge.
    task automatic step(input int v, input int h);
        @(posedge clk);
        #1;
        bus.vpos = 10'(v);
        bus.hpos = 10'(h);
    endtask

    // Vertical blanking, away from any word boundary: no video fetch.
    task automatic park(input int n);
        for (int i = 0; i < n; i++) step(490, 100);
    endtask

    task automatic host(input logic req, input logic we, input logic [11:0] a,
                        input logic [7:0] d);
        bus.host_req   = req;
        bus.host_we    = we;
        bus.host_addr  = a;
        bus.host_wdata = d;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_en"},      int'(bus.mem_en),      0);
        check({tag, "_mem_we"},      int'(bus.mem_we),      0);
        check({tag, "_mem_addr"},    int'(bus.mem_addr),    0);
        check({tag, "_mem_wdata"},   int'(bus.mem_wdata),   0);
        check({tag, "_host_gnt"},    int'(bus.host_gnt),    0);
        check({tag, "_host_rvalid"}, int'(bus.host_rvalid), 0);
        check({tag, "_host_rdata"},  int'(bus.host_rdata),  0);
        check({tag, "_vid_word"},    int'(bus.vid_word),    0);
        check({tag, "_vid_strobe"},  int'(bus.vid_strobe),  0);
    endtask

    initial begin
        int g0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[0]     = 8'h11;
        ram[80]    = 8'h22;
        ram[79]    = 8'h33;
        ram[81]    = 8'hA5;
        ram[82]    = 8'h77;
        ram[12'h010] = 8'h3C;
        bus.mem_rdata = 8'h00;
        bus.hpos = 10'd100;
        bus.vpos = 10'd490;
        host(1'b0, 1'b0, 12'h000, 8'h00);

        #1 rst_n = 1'b0;
        #11;
        check_all_zero("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        park(3);

        // Line wrap onto the next line / next frame.
        step(9, 797);   exp_cmd(cyc + 1, 1'b0, 1'b0, 12'd0, 8'h00);  exp_vid(cyc + 3, 8'h11);
        park(1);
        step(15, 797);  exp_cmd(cyc + 1, 1'b0, 1'b0, 12'd80, 8'h00); exp_vid(cyc + 3, 8'h22);
        park(1);
        step(524, 797); exp_cmd(cyc + 1, 1'b0, 1'b0, 12'd0, 8'h00);  exp_vid(cyc + 3, 8'h11);
        park(4);

        // Mid-line fetch; strobe must land while hpos=8.
        step(16, 5);    exp_cmd(cyc + 1, 1'b0, 1'b0, 12'd81, 8'h00); exp_vid(cyc + 3, 8'hA5);
        step(16, 6);
        step(16, 7);
        step(16, 8);
        step(0, 629);   exp_cmd(cyc + 1, 1'b0, 1'b0, 12'd79, 8'h00); exp_vid(cyc + 3, 8'h33);
        step(0, 637);
        park(4);

        // Host write colliding with a video slot.
        step(20, 13);   host(1'b1, 1'b1, 12'h123, 8'h5A);
        exp_cmd(cyc + 1, 1'b0, 1'b0, 12'd82, 8'h00); exp_vid(cyc + 3, 8'h77);
        step(20, 14);   exp_cmd(cyc + 1, 1'b1, 1'b1, 12'h123, 8'h5A);
        step(20, 15);
        step(20, 16);   host(1'b0, 1'b0, 12'h000, 8'h00);
        park(4);

        // Host read in vertical blanking.
        step(500, 100); host(1'b1, 1'b0, 12'h010, 8'h00);
        exp_cmd(cyc + 1, 1'b1, 1'b0, 12'h010, 8'h00); exp_hrd(cyc + 3, 8'h3C);
        step(500, 101);
        step(500, 102); host(1'b0, 1'b0, 12'h000, 8'h00);
        park(3);

        // Read back the colliding write.
        step(500, 110); host(1'b1, 1'b0, 12'h123, 8'h00);
        exp_cmd(cyc + 1, 1'b1, 1'b0, 12'h123, 8'h00); exp_hrd(cyc + 3, 8'h5A);
        step(500, 111);
        step(500, 112); host(1'b0, 1'b0, 12'h000, 8'h00);
        park(3);

        // Blanking throughput: request held 10 cycles -> 5 grants, every other cycle.
        g0 = gnt_cnt;
        for (int i = 0; i < 10; i++) begin
            step(490, 200 + i);
            host(1'b1, 1'b1, 12'h200 + 12'((i + 1) / 2), 8'h40 + 8'(i));
            if (i % 2 == 0) exp_cmd(cyc + 1, 1'b1, 1'b1, 12'h200 + 12'(i / 2), 8'h40 + 8'(i));
        end
        step(490, 210); host(1'b0, 1'b0, 12'h000, 8'h00);
        park(3);
        check("blank_gnt_count", gnt_cnt - g0, 5);

        // Display and host read words hold between strobes.
        check("vid_word_hold", int'(bus.vid_word), 8'h77);
        check("host_rdata_hold", int'(bus.host_rdata), 8'h5A);

        // Asynchronous reset with a host read in flight.
        step(500, 300); host(1'b1, 1'b0, 12'h010, 8'h00);
        @(posedge clk);
        #2 rst_n = 1'b0;
        host(1'b0, 1'b0, 12'h000, 8'h00);
        #1;
        check_all_zero("midreset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        park(6);

        check("scoreboard_drained", cmd_q.size() + vid_q.size() + hrd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
